plab4_net_ring_domain_sched: RTL and testbench
==============================================

PLAB4_NET_RING_DOMAIN_SCHED -- requirements
Module: plab4_net_ring_domain_sched

Interface
REQ-001 Parameter c_num_ports, default 8, number of ring routers.
REQ-002 Parameter p_slot_cycles, default 4, cycles per domain launch slot; legal range 1..255.
REQ-003 Parameter p_dead_cycles, default 2, drain cycles after each slot; legal range 0..255; must be at least the worst-case ring hop latency.
REQ-004 clk  input  1  clock, label {L}.
REQ-005 reset  input  1  synchronous, active-high reset, label {L}.
REQ-006 strict  input  1  1 = fixed TDMA schedule (timing protected); 0 = work-conserving slot skipping; label {L}.
REQ-007 req_d0  input  c_num_ports  per-router "flit waiting to enter ring" for domain 0, label {D1}.
REQ-008 req_d1  input  c_num_ports  per-router "flit waiting to enter ring" for domain 1, label {D2}.
REQ-009 link_domain  output  1  current ring-link owner; drives every router's out0_domain/out1_domain select.
REQ-010 grant_d0  output  c_num_ports  per-router launch permit, domain 0.
REQ-011 grant_d1  output  c_num_ports  per-router launch permit, domain 1.
REQ-012 slot_active  output  1  high while in a SLOT state.
REQ-013 switch_cnt  output  8  count of ownership changes, wraps 255->0.

Function
REQ-014 FSM states SLOT_D0, DEAD_D0, SLOT_D1, DEAD_D1; down-counter cnt sized to hold max(p_slot_cycles, p_dead_cycles).
REQ-015 On entry to SLOT_Dx, cnt = p_slot_cycles-1; on entry to DEAD_Dx, cnt = p_dead_cycles-1; otherwise cnt decrements each cycle.
REQ-016 When cnt==0 in SLOT_Dx: go to DEAD_Dx; if p_dead_cycles==0, make the DEAD_Dx exit decision immediately instead.
REQ-017 When cnt==0 in DEAD_Dx: go to SLOT of the other domain, except when strict==0, the other domain's req vector is all-zero and the own domain's req is non-zero; then re-enter SLOT_Dx.
REQ-018 When strict==1, the sequence is fixed regardless of req: period = 2*(p_slot_cycles+p_dead_cycles) cycles.
REQ-019 strict is sampled only at the DEAD exit decision; changing it mid-slot has no effect until the next boundary.
REQ-020 link_domain = 0 in SLOT_D0/DEAD_D0, 1 in SLOT_D1/DEAD_D1; it is registered and changes only on a SLOT_D0/SLOT_D1 transition, never during DEAD, so in-flight flits drain under their own domain.
REQ-021 grant_dx = req_dx when in SLOT_Dx, else all-zero; combinational from registered state plus req; grants for the non-owning domain are always 0.
REQ-022 No grant may be asserted in any DEAD state or during the cycle reset is high.
REQ-023 switch_cnt increments by 1 on each cycle where link_domain changes value; a re-entered SLOT (REQ-017 skip) does not increment it.
REQ-024 In strict mode, no output timing may depend on req_d0/req_d1 other than grant_dx's value within its own slot.

Reset
REQ-025 While reset is high, on the next clk edge: state=SLOT_D0, cnt=p_slot_cycles-1, link_domain=0, switch_cnt=0; slot_active reads 1 after reset, and grants are forced 0 while reset is high.
REQ-026 Reset mid-slot or mid-drain aborts the schedule immediately; there is no drain on reset.

Structure
REQ-027 State encodings (2-bit) and a helper clog2 macro belong in the shared plab4-net package header; the ring's PREV/NEXT macros are not redefined.
REQ-028 The module is a single FSM plus counter; the cnt down-counter may be a vc-style counter sub-module named plab4_net_SlotTimer.
REQ-029 The ring top instantiates one scheduler, fanning out link_domain to all routers and gating terminal in_val with the grants.

Verification
REQ-030 Reset, strict=1, slot=4, dead=2, no req -> link_domain pattern 0 x6, 1 x6, repeating; switch_cnt=2 after 12 cycles.
REQ-031 strict=1, req_d0=8'h05 held constant -> grant_d0=8'h05 exactly in the 4 SLOT_D0 cycles of each period, 0 elsewhere; grant_d1 never nonzero.
REQ-032 strict=0, req_d0=8'h01, req_d1=0 -> SLOT_D0 re-entered continuously, link_domain stays 0, switch_cnt stays 0; raise req_d1[3] -> ownership moves to 1 at the next DEAD_D0 exit.
REQ-033 strict=1 with random req_d1 vs req_d1=0 -> link_domain, slot_active and switch_cnt traces are cycle-identical (noninterference).
REQ-034 dead=0 -> SLOT_D0 x4 then SLOT_D1 x4 directly, no grant-free gap; assert reset in cycle 2 of SLOT_D1 -> next cycle state SLOT_D0, all grants 0 during reset.
REQ-035 Run 256 switches -> switch_cnt wraps to 0.

Source files
------------

// File: rtl/plab4_net_ring_domain_sched_pkg.sv
// Shared types and helpers for the ring domain scheduler: state encoding,
// counter sizing and state-to-domain mapping.
package plab4_net_ring_domain_sched_pkg;

  typedef enum logic [1:0] {
    SLOT_D0 = 2'd0,
    DEAD_D0 = 2'd1,
    SLOT_D1 = 2'd2,
    DEAD_D1 = 2'd3
  } sched_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Counter must hold the larger of the two reload values; never narrower than 1 bit.
  function automatic int cnt_width(input int slot_cycles, input int dead_cycles);
    int max_val;
    max_val = (slot_cycles > dead_cycles) ? slot_cycles : dead_cycles;
    return (clog2(max_val + 1) < 1) ? 1 : clog2(max_val + 1);
  endfunction

  function automatic logic state_domain(input sched_state_t s);
    return (s == SLOT_D1) || (s == DEAD_D1);
  endfunction

  function automatic logic state_is_slot(input sched_state_t s);
    return (s == SLOT_D0) || (s == SLOT_D1);
  endfunction

endpackage

// File: rtl/plab4_net_ring_domain_sched.sv
// Two-domain TDMA scheduler for the ring network: alternates launch slots
// with drain periods, optionally skipping an idle domain's slot.
module plab4_net_ring_domain_sched
  import plab4_net_ring_domain_sched_pkg::*;
#(
  parameter int c_num_ports   = 8,
  parameter int p_slot_cycles = 4,
  parameter int p_dead_cycles = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   strict,
  input  logic [c_num_ports-1:0] req_d0,
  input  logic [c_num_ports-1:0] req_d1,
  output logic                   link_domain,
  output logic [c_num_ports-1:0] grant_d0,
  output logic [c_num_ports-1:0] grant_d1,
  output logic                   slot_active,
  output logic [7:0]             switch_cnt
);

  localparam int c_cnt_w = cnt_width(p_slot_cycles, p_dead_cycles);
  localparam logic [c_cnt_w-1:0] c_slot_load = c_cnt_w'(p_slot_cycles - 1);
  localparam logic [c_cnt_w-1:0] c_dead_load =
    (p_dead_cycles == 0) ? '0 : c_cnt_w'(p_dead_cycles - 1);

  sched_state_t        state;
  sched_state_t        state_next;
  logic [c_cnt_w-1:0]  cnt;
  logic [c_cnt_w-1:0]  cnt_next;
  logic                cur_domain;
  logic                stay;
  logic                exit_domain;
  logic [c_num_ports-1:0] own_req;
  logic [c_num_ports-1:0] other_req;

  assign cur_domain = state_domain(state);
  assign own_req    = cur_domain ? req_d1 : req_d0;
  assign other_req  = cur_domain ? req_d0 : req_d1;

  // Work-conserving skip: keep the ring only if the other domain is idle and we are not.
  assign stay        = !strict && (other_req == '0) && (own_req != '0);
  assign exit_domain = stay ? cur_domain : ~cur_domain;

  always_comb begin
    state_next = state;
    cnt_next   = cnt - 1'b1;
    case (state)
      SLOT_D0, SLOT_D1: begin
        if (cnt == '0) begin
          if (p_dead_cycles == 0) begin
            state_next = exit_domain ? SLOT_D1 : SLOT_D0;
            cnt_next   = c_slot_load;
          end else begin
            state_next = (state == SLOT_D1) ? DEAD_D1 : DEAD_D0;
            cnt_next   = c_dead_load;
          end
        end
      end
      default: begin
        if (cnt == '0) begin
          state_next = exit_domain ? SLOT_D1 : SLOT_D0;
          cnt_next   = c_slot_load;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SLOT_D0;
      cnt         <= c_slot_load;
      link_domain <= 1'b0;
      switch_cnt  <= 8'd0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      link_domain <= state_domain(state_next);
      if (state_domain(state_next) != link_domain)
        switch_cnt <= switch_cnt + 8'd1;
    end
  end

  assign slot_active = state_is_slot(state);
  assign grant_d0    = (!reset && state == SLOT_D0) ? req_d0 : '0;
  assign grant_d1    = (!reset && state == SLOT_D1) ? req_d1 : '0;

endmodule

// File: tb/tb_plab4_net_ring_domain_sched.sv
// Bench for the ring domain scheduler: two instances (with and without drain
// cycles) checked against a slot/drain schedule model plus directed patterns.
module tb_plab4_net_ring_domain_sched;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       stc [2];
  logic [7:0] rq0 [2];
  logic [7:0] rq1 [2];
  logic       ld  [2];
  logic       sa  [2];
  logic [7:0] g0  [2];
  logic [7:0] g1  [2];
  logic [7:0] sw  [2];

  logic       nxt_rst [2];
  logic       nxt_stc [2];
  logic [7:0] nxt_rq0 [2];
  logic [7:0] nxt_rq1 [2];

  int         smp_t  [2];
  logic       smp_ld [2];
  logic       smp_sa [2];
  logic [7:0] smp_g0 [2];
  logic [7:0] smp_g1 [2];
  logic [7:0] smp_sw [2];

  int m_valid [2];
  int m_dom   [2];
  int m_slot  [2];
  int m_el    [2];
  int m_sw    [2];
  int m_t     [2];
  int slot_len [2];
  int dead_len [2];

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 clk = ~clk;

  plab4_net_ring_domain_sched #(.c_num_ports(8), .p_slot_cycles(4), .p_dead_cycles(2)) dut (
    .clk(clk), .reset(rst[0]), .strict(stc[0]), .req_d0(rq0[0]), .req_d1(rq1[0]),
    .link_domain(ld[0]), .grant_d0(g0[0]), .grant_d1(g1[0]),
    .slot_active(sa[0]), .switch_cnt(sw[0])
  );

  plab4_net_ring_domain_sched #(.c_num_ports(8), .p_slot_cycles(4), .p_dead_cycles(0)) dut_nodead (
    .clk(clk), .reset(rst[1]), .strict(stc[1]), .req_d0(rq0[1]), .req_d1(rq1[1]),
    .link_domain(ld[1]), .grant_d0(g0[1]), .grant_d1(g1[1]),
    .slot_active(sa[1]), .switch_cnt(sw[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Schedule model: a slot lasts slot_len cycles, then a drain of dead_len cycles,
  // then ownership is decided from strict and the request vectors.
  task automatic modelStep(input int i);
    int own;
    int other;
    int limit;
    bit stay;
    if (rst[i]) begin
      m_valid[i] = 1; m_dom[i] = 0; m_slot[i] = 1; m_el[i] = 0; m_sw[i] = 0; m_t[i] = 0;
    end else if (m_valid[i] != 0) begin
      m_t[i]++;
      own   = (m_dom[i] == 1) ? int'(rq1[i]) : int'(rq0[i]);
      other = (m_dom[i] == 1) ? int'(rq0[i]) : int'(rq1[i]);
      stay  = !stc[i] && other == 0 && own != 0;
      limit = (m_slot[i] != 0) ? slot_len[i] : dead_len[i];
      if (m_el[i] + 1 < limit) m_el[i]++;
      else if (m_slot[i] != 0 && dead_len[i] > 0) begin
        m_slot[i] = 0; m_el[i] = 0;
      end else begin
        if (!stay) begin
          m_dom[i] = 1 - m_dom[i];
          m_sw[i]  = (m_sw[i] + 1) % 256;
        end
        m_slot[i] = 1; m_el[i] = 0;
      end
    end
  endtask

  task automatic applyStimulus();
    logic [7:0] eg0;
    logic [7:0] eg1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rst[i] = nxt_rst[i]; stc[i] = nxt_stc[i]; rq0[i] = nxt_rq0[i]; rq1[i] = nxt_rq1[i];
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      smp_t[i] = m_t[i]; smp_ld[i] = ld[i]; smp_sa[i] = sa[i];
      smp_g0[i] = g0[i]; smp_g1[i] = g1[i]; smp_sw[i] = sw[i];
      if (m_valid[i] != 0) begin
        checkOutput($sformatf("link%0d", i), ld[i], m_dom[i]);
        checkOutput($sformatf("slot%0d", i), sa[i], m_slot[i]);
        checkOutput($sformatf("swcnt%0d", i), sw[i], m_sw[i]);
      end
      if (m_valid[i] != 0 || rst[i]) begin
        eg0 = (!rst[i] && m_slot[i] != 0 && m_dom[i] == 0) ? rq0[i] : 8'h00;
        eg1 = (!rst[i] && m_slot[i] != 0 && m_dom[i] == 1) ? rq1[i] : 8'h00;
        checkOutput($sformatf("grant0_%0d", i), g0[i], eg0);
        checkOutput($sformatf("grant1_%0d", i), g1[i], eg1);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i);
  endtask

  task automatic doReset();
    nxt_rst[0] = 1'b1; nxt_rst[1] = 1'b1;
    applyStimulus();
    nxt_rst[0] = 1'b0; nxt_rst[1] = 1'b0;
  endtask

  logic [9:0] trace_a [40];
  logic [7:0] stored_rq0 [40];
  int waited;

  initial begin
    slot_len[0] = 4; dead_len[0] = 2;
    slot_len[1] = 4; dead_len[1] = 0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_dom[i] = 0; m_slot[i] = 1; m_el[i] = 0; m_sw[i] = 0; m_t[i] = 0;
      rst[i] = 1'b1; stc[i] = 1'b1; rq0[i] = 8'h00; rq1[i] = 8'h00;
      nxt_rst[i] = 1'b0; nxt_stc[i] = 1'b1; nxt_rq0[i] = 8'h00; nxt_rq1[i] = 8'h00;
    end

    // Strict schedule with fixed requests; drainless instance gets reset mid-slot.
    doReset();
    for (int c = 0; c < 36; c++) begin
      nxt_stc[0] = 1'b1; nxt_rq0[0] = 8'h05; nxt_rq1[0] = 8'h00;
      nxt_stc[1] = 1'b1; nxt_rq0[1] = 8'hff; nxt_rq1[1] = 8'hff;
      nxt_rst[1] = (c == 5);
      applyStimulus();
      checkOutput("p30_link", smp_ld[0], (smp_t[0] / 6) % 2);
      if (smp_t[0] == 12) checkOutput("p30_sw12", smp_sw[0], 2);
      checkOutput("p31_g0", smp_g0[0], ((smp_t[0] % 12) < 4) ? 8'h05 : 8'h00);
      checkOutput("p31_g1", smp_g1[0], 0);
      if (c < 5) begin
        checkOutput("p34_link", smp_ld[1], (c / 4) % 2);
        checkOutput("p34_gap", smp_g0[1] | smp_g1[1], 8'hff);
      end
      if (c == 5) checkOutput("p34_rstgrant", smp_g0[1] | smp_g1[1], 0);
      if (c == 6) begin
        checkOutput("p34_rstlink", smp_ld[1], 0);
        checkOutput("p34_rstslot", smp_sa[1], 1);
      end
    end
    nxt_rst[1] = 1'b0;

    // Work-conserving: domain 0 keeps the ring while domain 1 is idle.
    doReset();
    nxt_stc[0] = 1'b0; nxt_rq0[0] = 8'h01; nxt_rq1[0] = 8'h00;
    for (int c = 0; c < 30; c++) begin
      applyStimulus();
      checkOutput("p32_link", smp_ld[0], 0);
      checkOutput("p32_sw", smp_sw[0], 0);
    end
    nxt_rq1[0] = 8'h08;
    waited = 0;
    applyStimulus();
    while (smp_ld[0] == 1'b0 && waited < 20) begin
      waited++;
      applyStimulus();
    end
    checkOutput("p32_handover", (waited <= 6), 1);

    // Noninterference: strict traces must not depend on domain 1 requests.
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      nxt_stc[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
        if (pass == 0) stored_rq0[c] = 8'($urandom);
        nxt_rq0[0] = stored_rq0[c];
        nxt_rq1[0] = (pass == 0) ? 8'($urandom) : 8'h00;
        applyStimulus();
        if (pass == 0) trace_a[c] = {smp_ld[0], smp_sa[0], smp_sw[0]};
        else checkOutput("p33_trace", {smp_ld[0], smp_sa[0], smp_sw[0]}, trace_a[c]);
      end
    end

    // Random mode toggling, sparse requests and occasional resets on both instances.
    doReset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        nxt_stc[i] = 1'($urandom);
        nxt_rq0[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        nxt_rq1[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        nxt_rst[i] = ($urandom_range(0, 63) == 0);
      end
      applyStimulus();
    end
    nxt_rst[0] = 1'b0; nxt_rst[1] = 1'b0;

    // Long strict run: 256 ownership changes bring the counter back to 0.
    doReset();
    nxt_stc[0] = 1'b1; nxt_rq0[0] = 8'h00; nxt_rq1[0] = 8'h00;
    nxt_stc[1] = 1'b1; nxt_rq0[1] = 8'h00; nxt_rq1[1] = 8'h00;
    for (int c = 0; c < 1540; c++) begin
      applyStimulus();
      checkOutput("p35_sw", smp_sw[0], (smp_t[0] / 6) % 256);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
